// File: rtl/cpu_mem_arbiter.sv
// N-port arbiter merging pipeline memory requesters onto the single cache CPU port.
// Optional per-port grant/wait counters when CPU_MEM_ARB_PERF_EN is defined.
module cpu_mem_arbiter #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned NUM_PORTS  = 2,
  parameter int unsigned ARB_MODE   = 0
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [NUM_PORTS-1:0]             req_valid,
  input  logic [NUM_PORTS-1:0]             req_wr,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0]  req_addr,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0]  req_wdata,
  output logic [NUM_PORTS-1:0]             req_ready,
  output logic [NUM_PORTS-1:0]             rsp_valid,
  output logic [DATA_WIDTH-1:0]            rsp_rdata,
  output logic [ADDR_WIDTH-1:0]            cpu_addr,
  output logic                             cpu_rd,
  output logic                             cpu_wr,
  output logic [DATA_WIDTH-1:0]            cpu_wdata,
  input  logic [DATA_WIDTH-1:0]            cpu_rdata,
  input  logic                             cpu_ready
`ifdef CPU_MEM_ARB_PERF_EN
  ,
  output logic [NUM_PORTS*32-1:0]          perf_grant_cnt,
  output logic [NUM_PORTS*32-1:0]          perf_wait_cnt
`endif
);

  localparam int unsigned IDX_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  typedef enum logic {IDLE, BUSY} state_e;

  state_e                 state_q;
  logic [IDX_W-1:0]       owner_q;
  logic [IDX_W-1:0]       last_q;
  logic [NUM_PORTS-1:0]   rsp_valid_q;
  logic [DATA_WIDTH-1:0]  rsp_rdata_q;
  logic [ADDR_WIDTH-1:0]  cpu_addr_q;
  logic                   cpu_rd_q;
  logic                   cpu_wr_q;
  logic [DATA_WIDTH-1:0]  cpu_wdata_q;

  logic                   win_any;
  logic [IDX_W-1:0]       win_idx;
  int unsigned            cand;
  logic                   win_wr;
  logic [ADDR_WIDTH-1:0]  win_addr;
  logic [DATA_WIDTH-1:0]  win_wdata;
  logic                   done;
  logic                   accept;

  // Search order: index 0 upward (fixed) or starting just after the last winner (round robin).
  always_comb begin
    win_any = 1'b0;
    win_idx = '0;
    cand    = 0;
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      if (ARB_MODE == 0) begin
        cand = i;
      end else begin
        cand = (32'(last_q) + 32'd1 + i) % NUM_PORTS;
      end
      if (!win_any && req_valid[cand]) begin
        win_any = 1'b1;
        win_idx = IDX_W'(cand);
      end
    end
  end

  always_comb begin
    win_wr    = req_wr[win_idx];
    win_addr  = req_addr[32'(win_idx) * ADDR_WIDTH +: ADDR_WIDTH];
    win_wdata = req_wdata[32'(win_idx) * DATA_WIDTH +: DATA_WIDTH];
  end

  // A new request may be taken in IDLE or in the completion cycle of the current one.
  always_comb begin
    done   = (state_q == BUSY) && cpu_ready;
    accept = win_any && ((state_q == IDLE) || done);
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      req_ready[i] = accept && (win_idx == IDX_W'(i));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      owner_q     <= '0;
      last_q      <= IDX_W'(NUM_PORTS - 1);
      rsp_valid_q <= '0;
      rsp_rdata_q <= '0;
      cpu_addr_q  <= '0;
      cpu_rd_q    <= 1'b0;
      cpu_wr_q    <= 1'b0;
      cpu_wdata_q <= '0;
    end else begin
      rsp_valid_q <= '0;
      if (done) begin
        rsp_valid_q[owner_q] <= 1'b1;
        if (cpu_rd_q) begin
          rsp_rdata_q <= cpu_rdata;
        end
      end
      case (state_q)
        IDLE: begin
          if (accept) begin
            cpu_addr_q <= win_addr;
            if (win_wr) begin
              cpu_wdata_q <= win_wdata;
            end
            cpu_rd_q <= !win_wr;
            cpu_wr_q <= win_wr;
            owner_q  <= win_idx;
            last_q   <= win_idx;
            state_q  <= BUSY;
          end
        end
        BUSY: begin
          if (accept) begin
            cpu_addr_q <= win_addr;
            if (win_wr) begin
              cpu_wdata_q <= win_wdata;
            end
            cpu_rd_q <= !win_wr;
            cpu_wr_q <= win_wr;
            owner_q  <= win_idx;
            last_q   <= win_idx;
          end else if (done) begin
            cpu_rd_q <= 1'b0;
            cpu_wr_q <= 1'b0;
            state_q  <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign cpu_addr  = cpu_addr_q;
  assign cpu_rd    = cpu_rd_q;
  assign cpu_wr    = cpu_wr_q;
  assign cpu_wdata = cpu_wdata_q;

`ifdef CPU_MEM_ARB_PERF_EN
  logic [31:0] grant_cnt_q [NUM_PORTS];
  logic [31:0] wait_cnt_q  [NUM_PORTS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned p = 0; p < NUM_PORTS; p++) begin
        grant_cnt_q[p] <= '0;
        wait_cnt_q[p]  <= '0;
      end
    end else begin
      for (int unsigned p = 0; p < NUM_PORTS; p++) begin
        if (req_valid[p] && req_ready[p]) begin
          grant_cnt_q[p] <= grant_cnt_q[p] + 32'd1;
        end
        if (req_valid[p] && !req_ready[p]) begin
          wait_cnt_q[p] <= wait_cnt_q[p] + 32'd1;
        end
      end
    end
  end

  always_comb begin
    for (int unsigned p = 0; p < NUM_PORTS; p++) begin
      perf_grant_cnt[p*32 +: 32] = grant_cnt_q[p];
      perf_wait_cnt[p*32 +: 32]  = wait_cnt_q[p];
    end
  end
`endif

endmodule
